// File: rtl/autoscale_block_nch_pkg.sv
// autoscale_block_nch_pkg: shift width helper, read-side FSM states and the shift clamp
package autoscale_block_nch_pkg;
  typedef enum logic [1:0] {IDLE, CALC, READ} state_t;
  function automatic int shift_w(input int din_width);
    return $clog2(din_width);
  endfunction
  function automatic int clamp_shift(input int p, input logic zero, input int tgt, input int min_s, input int max_s);
    return zero ? max_s : (p > tgt) ? 0 : (tgt - p > max_s) ? max_s : (tgt - p < min_s) ? 0 : tgt - p;
  endfunction
endpackage

// File: rtl/autoscale_block_nch_if.sv
// autoscale_block_nch_if: sample stream in, normalised stream plus applied shift out
interface autoscale_block_nch_if
  import autoscale_block_nch_pkg::*;
#(
  parameter int DIN_WIDTH = 16,
  parameter int NUM_CH = 2,
  parameter int SHIFT_W = shift_w(DIN_WIDTH)
) ();
  logic [NUM_CH*DIN_WIDTH-1:0] din;
  logic [NUM_CH*DIN_WIDTH-1:0] dout;
  logic din_valid;
  logic dout_valid;
  logic dout_last;
  logic [SHIFT_W-1:0] shift_value;
  modport master(output din, din_valid, input dout, dout_valid, dout_last, shift_value);
  modport slave(input din, din_valid, output dout, dout_valid, dout_last, shift_value);
endinterface

// File: rtl/autoscale_block_nch_leading_one_detect.sv
// leading_one_detect: registered index of the highest set bit plus an all-zero flag
module leading_one_detect #(
  parameter int DIN_WIDTH = 16,
  parameter int SHIFT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIN_WIDTH-1:0] din,
  output logic [SHIFT_W-1:0]   idx,
  output logic                 zero
);
  logic [SHIFT_W-1:0] idx_c;
  // priority scan: the highest set bit wins
  always_comb begin
    idx_c = '0;
    for (int i = 0; i < DIN_WIDTH; i++)
      if (din[i]) idx_c = SHIFT_W'(i);
  end
  // register the index so it is stable one cycle after the peak is latched
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      zero <= 1'b1;
    end else begin
      idx <= idx_c;
      zero <= din == '0;
    end
endmodule

// File: rtl/autoscale_block_nch.sv
// autoscale_block_nch: block-floating-point normaliser; AUTOSCALE_SIGNED_EN selects two's complement lanes
module autoscale_block_nch
  import autoscale_block_nch_pkg::*;
#(
  parameter int DIN_WIDTH = 16,
  parameter int NUM_CH = 2,
  parameter int BLOCK_LEN = 4,
  parameter int MAX_SHIFT = 10,
  parameter int MIN_SHIFT = 2,
  parameter int HEADROOM = 1
) (
  input logic clk,
  input logic rst_n,
  autoscale_block_nch_if.slave s
);
  localparam int SHIFT_W = shift_w(DIN_WIDTH);
  localparam int CNT_W = $clog2(BLOCK_LEN + 1);
  localparam int ADDR_W = $clog2(2 * BLOCK_LEN);
  localparam int DW = NUM_CH * DIN_WIDTH;
`ifdef AUTOSCALE_SIGNED_EN
  localparam int TGT = DIN_WIDTH - 2 - HEADROOM;
`else
  localparam int TGT = DIN_WIDTH - 1 - HEADROOM;
`endif
  logic [DW-1:0] mem [2*BLOCK_LEN];
  logic [DW-1:0] rd_data;
  logic [DIN_WIDTH-1:0] mag, acc, peak;
  logic [CNT_W-1:0] wr_cnt, rd_cnt;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [SHIFT_W-1:0] lod_idx, shift_reg, sh1;
  logic bank_sel, b1, b2, rd_bank, w1, w2, v1, l1, wrap, rd_end, lod_zero;
  state_t state, state_nx;
  assign wrap = s.din_valid && wr_cnt == CNT_W'(BLOCK_LEN - 1);
  assign rd_end = state == READ && rd_cnt == CNT_W'(BLOCK_LEN - 1);
  assign wr_addr = bank_sel ? ADDR_W'(BLOCK_LEN) + ADDR_W'(wr_cnt) : ADDR_W'(wr_cnt);
  assign rd_addr = rd_bank ? ADDR_W'(BLOCK_LEN) + ADDR_W'(rd_cnt) : ADDR_W'(rd_cnt);
  // OR of the lane magnitudes of the incoming sample
  always_comb begin
    mag = '0;
    for (int k = 0; k < NUM_CH; k++)
`ifdef AUTOSCALE_SIGNED_EN
      mag = mag | (s.din[k*DIN_WIDTH +: DIN_WIDTH] ^ {DIN_WIDTH{s.din[k*DIN_WIDTH + DIN_WIDTH - 1]}});
`else
      mag = mag | s.din[k*DIN_WIDTH +: DIN_WIDTH];
`endif
  end
  // write side: sample counter, bank toggle, peak accumulation and the two-stage block-done pipe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_cnt <= '0;
      bank_sel <= 1'b0;
      acc <= '0;
      peak <= '0;
      w1 <= 1'b0;
      w2 <= 1'b0;
      b1 <= 1'b0;
      b2 <= 1'b0;
    end else begin
      w1 <= wrap;
      w2 <= w1;
      b1 <= bank_sel;
      b2 <= b1;
      if (s.din_valid) begin
        wr_cnt <= wrap ? '0 : wr_cnt + 1'b1;
        bank_sel <= bank_sel ^ wrap;
        acc <= wrap ? '0 : acc | mag;
        if (wrap) peak <= acc | mag;
      end
    end
  // ping-pong store, read-first so a reused bank returns the old sample
  always_ff @(posedge clk) begin
    if (s.din_valid) mem[wr_addr] <= s.din;
    rd_data <= mem[rd_addr];
  end
  leading_one_detect #(.DIN_WIDTH(DIN_WIDTH), .SHIFT_W(SHIFT_W)) u_lod (
    .clk(clk), .rst_n(rst_n), .din(peak), .idx(lod_idx), .zero(lod_zero)
  );
  // read-side state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // a computed shift always starts a readout; a pending block parks in CALC
  always_comb
    state_nx = w2 ? READ : (state == READ && !rd_end) ? READ : (wrap || w1) ? CALC : IDLE;
  // read address sequencing and the shift that travels with each read
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_cnt <= '0;
      rd_bank <= 1'b0;
      shift_reg <= '0;
      v1 <= 1'b0;
      l1 <= 1'b0;
      sh1 <= '0;
    end else begin
      v1 <= state == READ;
      l1 <= rd_end;
      sh1 <= shift_reg;
      if (w2) begin
        rd_cnt <= '0;
        rd_bank <= b2;
        shift_reg <= SHIFT_W'(clamp_shift(int'(lod_idx), lod_zero, TGT, MIN_SHIFT, MAX_SHIFT));
      end else if (state == READ) rd_cnt <= rd_cnt + 1'b1;
    end
  // output stage: per-lane logical shift, shift value held alongside the data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s.dout <= '0;
      s.dout_valid <= 1'b0;
      s.dout_last <= 1'b0;
      s.shift_value <= '0;
    end else begin
      s.dout_valid <= v1;
      s.dout_last <= v1 && l1;
      if (v1) begin
        s.shift_value <= sh1;
        for (int k = 0; k < NUM_CH; k++)
          s.dout[k*DIN_WIDTH +: DIN_WIDTH] <= rd_data[k*DIN_WIDTH +: DIN_WIDTH] << sh1;
      end
    end
endmodule

// File: tb/tb_autoscale_block_nch.sv
// tb_autoscale_block_nch: random and directed blocks scored against a block-level model
module tb_autoscale_block_nch;
  localparam int BL = 4;
  localparam int MAX_S = 10;
  localparam int MIN_S = 2;
`ifdef AUTOSCALE_SIGNED_EN
  localparam int TGT = 13;
`else
  localparam int TGT = 14;
`endif
  typedef struct {
    int cyc;
    logic [31:0] dout;
    logic last;
    logic [3:0] sh;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [31:0] blk[$];
  autoscale_block_nch_if #(.DIN_WIDTH(16), .NUM_CH(2)) bus ();
  autoscale_block_nch #(
    .DIN_WIDTH(16), .NUM_CH(2), .BLOCK_LEN(BL), .MAX_SHIFT(MAX_S), .MIN_SHIFT(MIN_S), .HEADROOM(1)
  ) dut (.clk(clk), .rst_n(rst_n), .s(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
    end
  endtask
  function automatic int mag(input logic [15:0] x);
`ifdef AUTOSCALE_SIGNED_EN
    return $signed(x) < 0 ? -int'($signed(x)) - 1 : int'(x);
`else
    return int'(x);
`endif
  endfunction
  function automatic int calc_shift(input int m);
    int p, sh;
    if (m == 0) return MAX_S;
    p = $clog2(m + 1) - 1;
    sh = TGT - p;
    if (sh < 0) return 0;
    if (sh > MAX_S) return MAX_S;
    if (sh < MIN_S) return 0;
    return sh;
  endfunction
  function automatic logic [15:0] scale(input logic [15:0] x, input int sh);
    return 16'((int'(x) * (1 << sh)) % 65536);
  endfunction
  task automatic model_block();
    int m, sh;
    m = 0;
    foreach (blk[i])
      for (int k = 0; k < 2; k++)
        if (mag(blk[i][k*16 +: 16]) > m) m = mag(blk[i][k*16 +: 16]);
    sh = calc_shift(m);
    foreach (blk[i])
      q.push_back('{cyc: cyc + 5 + i, dout: {scale(blk[i][31:16], sh), scale(blk[i][15:0], sh)},
                    last: (i == BL - 1), sh: 4'(sh)});
    blk.delete();
  endtask
  task automatic step(input logic v, input logic [31:0] d);
    logic exp_v;
    @(negedge clk);
    cyc++;
    exp_v = q.size() > 0 && q[0].cyc == cyc;
    check("valid", 32'(bus.dout_valid), 32'(exp_v));
    check("last", 32'(bus.dout_last), exp_v ? 32'(q[0].last) : 32'd0);
    if (exp_v) begin
      check("dout", bus.dout, q[0].dout);
      check("shift", 32'(bus.shift_value), 32'(q[0].sh));
      void'(q.pop_front());
    end
    bus.din_valid = v;
    bus.din = d;
    if (v) begin
      blk.push_back(d);
      if (blk.size() == BL) model_block();
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    cyc++;
    rst_n = 1'b0;
    bus.din_valid = 1'b0;
    bus.din = '0;
    q.delete();
    blk.delete();
    #1;
    check("rst_valid", 32'(bus.dout_valid), 0);
    check("rst_last", 32'(bus.dout_last), 0);
    check("rst_dout", bus.dout, 0);
    check("rst_shift", 32'(bus.shift_value), 0);
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
  endtask
  task automatic send_block(input logic [31:0] s0, s1, s2, s3, input int gap);
    logic [31:0] s [4];
    s = '{s0, s1, s2, s3};
    for (int i = 0; i < BL; i++) begin
      step(1'b1, s[i]);
      if (i < BL - 1) repeat (gap) step(1'b0, 32'h0);
    end
  endtask
  function automatic logic [15:0] rnd_lane(input int k);
    logic [15:0] r;
    r = 16'($urandom);
`ifdef AUTOSCALE_SIGNED_EN
    return 16'($signed(r) >>> k);
`else
    return r >> k;
`endif
  endfunction
  task automatic rand_block(input int gap);
    int k;
    k = $urandom_range(0, 16);
    send_block({rnd_lane(k), rnd_lane(k)}, {rnd_lane(k), rnd_lane(k)},
               {rnd_lane(k), rnd_lane(k)}, {rnd_lane(k), rnd_lane(k)}, gap);
  endtask
  initial begin
    bus.din_valid = 1'b0;
    bus.din = '0;
    do_reset();
`ifdef AUTOSCALE_SIGNED_EN
    send_block({16'h0001, 16'hFF00}, {16'hFFFF, 16'h0010}, {16'h0020, 16'hFFC0}, {16'h0000, 16'h0005}, 0);
    repeat (8) step(1'b0, 32'h0);
    send_block({16'h7FFF, 16'h8000}, {16'h0001, 16'hFFFF}, 32'h0, 32'h0, 0);
    send_block({16'hFFFE, 16'h0003}, 32'h0, {16'h0000, 16'hFFF0}, 32'h0, 0);
`else
    send_block({16'h0012, 16'h0040}, {16'h0003, 16'h0021}, {16'h0000, 16'h0001}, {16'h003F, 16'h0010}, 0);
    repeat (8) step(1'b0, 32'h0);
    send_block(32'h0, 32'h0, 32'h0, 32'h0, 0);
    send_block({16'h1234, 16'h4000}, {16'h0001, 16'h2222}, 32'h0, {16'h3FFF, 16'h0F0F}, 0);
    send_block({16'h0800, 16'h0001}, {16'h0123, 16'h07FF}, {16'h0000, 16'h0400}, {16'h0010, 16'h0100}, 0);
    send_block({16'h2000, 16'h0003}, 32'h0, {16'h1FFF, 16'h0000}, 32'h1, 0);
    send_block({16'h8000, 16'h0001}, 32'h0, 32'h0, {16'h0000, 16'h7FFF}, 0);
    send_block(32'h0001_0001, 32'h0000_0001, 32'h0001_0000, 32'h0, 0);
`endif
    repeat (6) step(1'b0, 32'h0);
    rand_block(0);
    rand_block(0);
    rand_block(2);
    repeat (8) step(1'b0, 32'h0);
    step(1'b1, 32'h0100_0200);
    step(1'b1, 32'h0300_0400);
    do_reset();
    rand_block(0);
    repeat (6) step(1'b0, 32'h0);
    do_reset();
    repeat (6) step(1'b0, 32'h0);
    rand_block(0);
    repeat (8) step(1'b0, 32'h0);
    for (int n = 0; n < 30; n++) begin
      rand_block($urandom_range(0, 2));
      repeat ($urandom_range(0, 3)) step(1'b0, 32'h0);
    end
    repeat (12) step(1'b0, 32'h0);
    check("drain", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
